// File: rtl/bitserial_dot_mac.sv
// Bit-serial signed dot-product MAC: LANES activations times LANES weights,
// one weight bit per cycle, runtime weight precision, multi-vector accumulation.
module bitserial_dot_mac #(
    parameter int ACT_W = 8,
    parameter int WGT_W = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 24
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*ACT_W-1:0]   act,
    input  logic [LANES*WGT_W-1:0]   wgt,
    input  logic [1:0]               prec,
    input  logic                     acc_clear,
    input  logic                     last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         result,
    output logic                     ovf,
    output logic                     busy
);

    localparam int DOT_W  = ACT_W + WGT_W + $clog2(LANES);
    localparam int BIDX_W = $clog2(WGT_W);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t                   r_state;
    logic [LANES*ACT_W-1:0]   r_act;
    logic [LANES*WGT_W-1:0]   r_wgt;
    logic [BIDX_W-1:0]        r_plast;
    logic [BIDX_W-1:0]        r_bidx;
    logic                     r_clear;
    logic                     r_last;
    logic signed [DOT_W-1:0]  r_dot;
    logic [ACC_W-1:0]         r_acc;
    logic                     r_ovf;
    logic                     r_out_valid;
    logic                     r_busy;

    logic signed [DOT_W-1:0]  w_pp;
    logic signed [DOT_W-1:0]  w_term;
    logic signed [DOT_W-1:0]  w_dot_next;
    logic [ACC_W-1:0]         w_dot_ext;
    logic [ACC_W-1:0]         w_base;
    logic [ACC_W-1:0]         w_sum;
    logic                     w_add_ovf;
    logic                     w_last_bit;

    // Adder tree over lanes whose current weight bit is set.
    always_comb begin
        w_pp = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (r_wgt[i*WGT_W + 32'(r_bidx)])
                w_pp = w_pp + DOT_W'(signed'(r_act[i*ACT_W +: ACT_W]));
        end
    end

    // Top selected bit is the two's complement sign bit and carries negative weight.
    assign w_last_bit = (r_bidx == r_plast);
    assign w_term     = w_last_bit ? -w_pp : w_pp;
    assign w_dot_next = r_dot + (w_term <<< r_bidx);
    assign w_dot_ext  = ACC_W'(w_dot_next);
    assign w_base     = r_clear ? '0 : r_acc;
    assign w_sum      = w_base + w_dot_ext;
    assign w_add_ovf  = (w_base[ACC_W-1] == w_dot_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != w_base[ACC_W-1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_act       <= '0;
            r_wgt       <= '0;
            r_plast     <= '0;
            r_bidx      <= '0;
            r_clear     <= 1'b0;
            r_last      <= 1'b0;
            r_dot       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_act   <= act;
                        r_wgt   <= wgt;
                        r_clear <= acc_clear;
                        r_last  <= last;
                        case (prec)
                            2'b01:   r_plast <= BIDX_W'(WGT_W/2 - 1);
                            2'b10:   r_plast <= BIDX_W'(WGT_W/4 - 1);
                            default: r_plast <= BIDX_W'(WGT_W - 1);
                        endcase
                        r_bidx  <= '0;
                        r_dot   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_last_bit) begin
                        r_acc <= w_sum;
                        r_ovf <= (r_clear ? 1'b0 : r_ovf) | w_add_ovf;
                        r_dot <= '0;
                        if (r_last) begin
                            r_out_valid <= 1'b1;
                            r_state     <= OUT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_dot  <= w_dot_next;
                        r_bidx <= r_bidx + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_acc;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bitserial_dot_mac.sv
// Bench for bitserial_dot_mac: directed cases plus random vectors against an
// arithmetic reference model of the signed dot product and wrapping accumulator.
module tb_bitserial_dot_mac;

    localparam int ACT_W = 8;
    localparam int WGT_W = 8;
    localparam int LANES = 4;
    localparam int ACC_W = 24;

    logic                   clk;
    logic                   rstn;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*ACT_W-1:0] act;
    logic [LANES*WGT_W-1:0] wgt;
    logic [1:0]             prec;
    logic                   acc_clear;
    logic                   last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       result;
    logic                   ovf;
    logic                   busy;

    int n_total = 0;
    int n_bad   = 0;

    longint m_acc = 0;
    bit     m_ovf = 0;

    bitserial_dot_mac #(.ACT_W(ACT_W), .WGT_W(WGT_W), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .act(act), .wgt(wgt), .prec(prec), .acc_clear(acc_clear), .last(last),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int prec_bits(input logic [1:0] p);
        return (p == 2'b01) ? 4 : (p == 2'b10) ? 2 : 8;
    endfunction

    // Signed dot product with each weight truncated to its low P bits.
    function automatic longint ref_dot(input logic [31:0] a, input logic [31:0] w,
                                       input logic [1:0] p);
        int          pb;
        longint      s;
        longint      av;
        longint      wv;
        logic [7:0]  ab;
        logic [7:0]  wb;
        pb = prec_bits(p);
        s  = 0;
        for (int i = 0; i < LANES; i++) begin
            ab = a[i*8 +: 8];
            wb = w[i*8 +: 8];
            av = longint'($signed(ab));
            wv = longint'(wb) & ((longint'(1) << pb) - 1);
            if (wv >= (longint'(1) << (pb - 1))) wv = wv - (longint'(1) << pb);
            s = s + av * wv;
        end
        return s;
    endfunction

    function automatic longint res_signed();
        return longint'($signed(result));
    endfunction

    task automatic model_add(input longint d, input bit clr);
        longint s;
        s = (clr ? 0 : m_acc) + d;
        if (clr) m_ovf = 0;
        if (s > 8388607 || s < -8388608) m_ovf = 1;
        s = s & 64'hFF_FFFF;
        if (s >= 8388608) s = s - 16777216;
        m_acc = s;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] w, input logic [1:0] p,
                        input bit clr, input bit lst, input int hold, input bit ordy_run);
        int     n;
        int     k;
        longint held;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        act = a; wgt = w; prec = p; acc_clear = clr; last = lst;
        in_valid = 1'b1;
        out_ready = ordy_run;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        act = $urandom; wgt = $urandom; prec = 2'($urandom); acc_clear = 1'($urandom);
        last = 1'($urandom);
        model_add(ref_dot(a, w, p), clr);
        chk("busy_run", busy, 1);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid || in_ready) break;
        end
        chk("latency", n, prec_bits(p));
        if (lst) begin
            out_ready = 1'b0;
            chk("out_valid", out_valid, 1);
            chk("result", res_signed(), m_acc);
            chk("ovf", ovf, m_ovf);
            held = res_signed();
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                act = $urandom;
                @(posedge clk);
                #1;
                chk("hold_result", res_signed(), held);
                chk("hold_in_ready", in_ready, 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            m_acc = 0;
            m_ovf = 0;
            chk("drain_valid", out_valid, 0);
            chk("drain_result", res_signed(), 0);
            chk("drain_idle", in_ready, 1);
            chk("drain_busy", busy, 0);
        end else begin
            chk("cont_idle", in_ready, 1);
            chk("cont_no_valid", out_valid, 0);
            chk("cont_acc", res_signed(), m_acc);
        end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; act = '0; wgt = '0; prec = '0;
        acc_clear = 1'b0; last = 1'b0; out_ready = 1'b0;
        #23;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", res_signed(), 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;

        send(32'h6767_6767, 32'h0A0A_0A0A, 2'b00, 1, 1, 0, 0);
        chk("full_4120", m_acc == 0 ? 4120 : 0, 4120);
        send(32'h8080_8080, 32'h8080_8080, 2'b00, 1, 1, 0, 0);
        send(32'h0000_007F, 32'h0000_0080, 2'b00, 1, 1, 0, 0);
        send(32'h0000_003F, 32'h0000_00F7, 2'b01, 1, 1, 0, 0);
        send(32'h0000_000A, 32'h0000_0008, 2'b01, 1, 1, 0, 0);
        send(32'h0000_0005, 32'h0000_0003, 2'b10, 1, 1, 0, 0);
        send(32'h0000_0005, 32'h0000_0003, 2'b11, 1, 1, 0, 1);

        send(32'd100, 32'd100, 2'b00, 1, 0, 0, 0);
        send(32'd100, 32'd100, 2'b00, 0, 0, 0, 1);
        send(32'd100, 32'd100, 2'b00, 0, 1, 5, 0);

        for (int i = 0; i < 128; i++)
            send(32'h8080_8080, 32'h8080_8080, 2'b00, i == 0, i == 127, 0, 0);
        send(32'h6767_6767, 32'h0A0A_0A0A, 2'b00, 1, 1, 0, 0);

        // Reset mid-RUN with a non-zero accumulator from a continuation vector.
        send(32'h6767_6767, 32'h0A0A_0A0A, 2'b00, 1, 0, 0, 0);
        @(negedge clk);
        act = 32'h1111_1111; wgt = 32'h2222_2222; prec = 2'b00;
        acc_clear = 1'b0; last = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_result", res_signed(), 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_valid", out_valid, 0);
        @(negedge clk);
        rstn = 1'b1;
        m_acc = 0;
        m_ovf = 0;
        send(32'h6767_6767, 32'h0A0A_0A0A, 2'b00, 0, 1, 0, 0);

        for (int i = 0; i < 40; i++)
            send($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3), 1'($urandom));
        send($urandom, $urandom, 2'b00, 0, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
